// File: rtl/parking_occupancy_ctrl.sv
// Parking-lot occupancy controller: debounced entry/exit sensors, occupancy count with full/empty, timed gates.
// Optional statistics counters are compiled in with `define PARK_STATS_EN.
module parking_occupancy_ctrl #(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int DEB_CYCLES  = 4,
    parameter int GATE_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_sensor,
    input  logic             exit_sensor,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             entry_gate_open,
    output logic             exit_gate_open,
    output logic             entry_denied,
    output logic [15:0]      total_entries,
    output logic [7:0]       denied_count
);

    localparam int DEB_W = $clog2(DEB_CYCLES);
    localparam int TMR_W = $clog2(GATE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP_C     = CNT_W'(CAPACITY);

    typedef enum logic {G_CLOSED = 1'b0, G_OPEN = 1'b1} gate_t;

    // Index 0 is the entry sensor/gate, index 1 the exit sensor/gate.
    logic [1:0]       sens_s;
    logic [1:0]       deb_q, deb_d, deb_prev_q;
    logic [DEB_W-1:0] dcnt_q [2];
    logic [DEB_W-1:0] dcnt_d [2];
    gate_t            gst_q  [2];
    gate_t            gst_d  [2];
    logic [TMR_W-1:0] tmr_q  [2];
    logic [TMR_W-1:0] tmr_d  [2];
    logic [1:0]       acc_s;

    logic             ev_en_s, ev_ex_s;
    logic [CNT_W-1:0] mid_s;
    logic             deny_s;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d, denied_q;

    assign sens_s  = {exit_sensor, entry_sensor};
    assign ev_en_s = deb_q[0] & ~deb_prev_q[0];
    assign ev_ex_s = deb_q[1] & ~deb_prev_q[1];

    // Debounce: the level flips only after DEB_CYCLES consecutive opposite samples.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            dcnt_d[i] = '0;
            if (sens_s[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) begin
                    deb_d[i]  = ~deb_q[i];
                    dcnt_d[i] = '0;
                end else begin
                    dcnt_d[i] = dcnt_q[i] + DEB_W'(1);
                end
            end else begin
                dcnt_d[i] = '0;
            end
        end
    end

    // Occupancy: exit is applied first so a full lot can swap a car in one cycle.
    always_comb begin
        acc_s    = 2'b00;
        acc_s[1] = ev_ex_s & (count_q != '0);
        mid_s    = count_q - CNT_W'(acc_s[1]);
        acc_s[0] = ev_en_s & (mid_s < CAP_C);
        deny_s   = ev_en_s & ~acc_s[0];
        count_d  = mid_s + CNT_W'(acc_s[0]);
        full_d   = (count_d == CAP_C);
        empty_d  = (count_d == '0);
    end

    // Gate FSMs: an accepted event opens or re-arms; the timer closes the gate.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            gst_d[g] = gst_q[g];
            tmr_d[g] = tmr_q[g];
            case (gst_q[g])
                G_CLOSED: begin
                    if (acc_s[g]) begin
                        gst_d[g] = G_OPEN;
                        tmr_d[g] = GATE_LOAD;
                    end else begin
                        tmr_d[g] = '0;
                    end
                end
                G_OPEN: begin
                    if (acc_s[g]) begin
                        tmr_d[g] = GATE_LOAD;
                    end else if (tmr_q[g] == '0) begin
                        gst_d[g] = G_CLOSED;
                    end else begin
                        tmr_d[g] = tmr_q[g] - TMR_W'(1);
                    end
                end
                default: begin
                    gst_d[g] = G_CLOSED;
                    tmr_d[g] = '0;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q      <= 2'b00;
            deb_prev_q <= 2'b00;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            denied_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i] <= '0;
                gst_q[i]  <= G_CLOSED;
                tmr_q[i]  <= '0;
            end
        end else begin
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            denied_q   <= deny_s;
            for (int i = 0; i < 2; i++) begin
                dcnt_q[i] <= dcnt_d[i];
                gst_q[i]  <= gst_d[i];
                tmr_q[i]  <= tmr_d[i];
            end
        end
    end

    assign count           = count_q;
    assign full            = full_q;
    assign empty           = empty_q;
    assign entry_gate_open = (gst_q[0] == G_OPEN);
    assign exit_gate_open  = (gst_q[1] == G_OPEN);
    assign entry_denied    = denied_q;

`ifdef PARK_STATS_EN
    logic [15:0] tot_q;
    logic [7:0]  den_q;

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            tot_q <= 16'h0000;
            den_q <= 8'h00;
        end else begin
            if (acc_s[0] && (tot_q != 16'hFFFF)) begin
                tot_q <= tot_q + 16'h0001;
            end
            if (deny_s && (den_q != 8'hFF)) begin
                den_q <= den_q + 8'h01;
            end
        end
    end

    assign total_entries = tot_q;
    assign denied_count  = den_q;
`else
    assign total_entries = 16'h0000;
    assign denied_count  = 8'h00;
`endif

endmodule
